// File: rtl/rr_mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux4_arb_pkg
// Shared types, constants and the rotate-priority pick function for the
// rr_mux4_arbiter slice (arbiter top, its bus interface and rr_pick4).
// ---------------------------------------------------------------------------
package rr_mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BCNT_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // First requester found scanning ptr+1, ptr+2, ... modulo NUM_REQ.
    // With exclude set, ptr itself is skipped unless it is the only requester.
    // Returns ptr when nothing is requesting.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input logic               exclude
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'(ptr + k);
            if (!found && req[idx] && !(exclude && (idx == ptr))) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter_if
// Request/ack side and downstream valid/ready side of the arbiter.
//   req[3:0], in0..in3 : requester valid + data, held until ack
//   ack[3:0]           : one-hot capture pulse back to the requesters
//   out_valid/out_ready/out_data/out_sel : registered downstream beat
// Modports: master = requesters + downstream sink, slave = arbiter.
// ---------------------------------------------------------------------------
interface rr_mux4_arbiter_if
    import rr_mux4_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 4
);
    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  in0;
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
    logic [DATA_W-1:0]  in3;
    logic [NUM_REQ-1:0] ack;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [IDX_W-1:0]   out_sel;

    modport master (
        output req, in0, in1, in2, in3, out_ready,
        input  ack, out_valid, out_data, out_sel
    );

    modport slave (
        input  req, in0, in1, in2, in3, out_ready,
        output ack, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational rotate-priority encoder over four requests.
//   req[3:0]  : pending requests
//   ptr[1:0]  : last owner; scanning starts at ptr+1
//   exclude   : skip ptr unless it is the sole requester
//   win_c[1:0]: selected index (ptr when nothing requests)
// ---------------------------------------------------------------------------
module rr_pick4
    import rr_mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               exclude,
    output logic [IDX_W-1:0]   win_c
);
    assign win_c = rr_pick(req, ptr, exclude);
endmodule

// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
// Round-robin arbiter with per-owner burst hold in front of a 4:1 select
// datapath. Captures the winning input into a one-beat output buffer and
// presents it on a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : rr_mux4_arbiter_if.slave (req/in0..in3/ack, out_* handshake)
// Optional (macro RR_MUX4_ARB_STATS_EN):
//   clr_stats            : clears the grant counters
//   grant_cnt0..3 [CNT_W]: saturating per-requester ack counters
// ---------------------------------------------------------------------------
module rr_mux4_arbiter
    import rr_mux4_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 8
)
(
    input  logic              clk,
    input  logic              rst,
`ifdef RR_MUX4_ARB_STATS_EN
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  grant_cnt2,
    output logic [CNT_W-1:0]  grant_cnt3,
`endif
    rr_mux4_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_BURST = 1'(BURST);

    if ((BURST_LEN < 1) || (BURST_LEN > 15) || (CNT_W < 1)) begin : g_param_chk
        $error("rr_mux4_arbiter: BURST_LEN must be 1..15 and CNT_W >= 1");
    end

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BCNT_W-1:0]  cnt_q, cnt_d;

    logic               valid_q;
    logic [DATA_W-1:0]  data_q;
    logic [IDX_W-1:0]   sel_q;

    logic [IDX_W-1:0]   pick_c;
    logic [IDX_W-1:0]   win_c;
    logic               cap_c;
    logic               hold_c;
    logic [NUM_REQ-1:0] ack_c;
    logic [DATA_W-1:0]  win_data_c;

    // Rotating scan from the current owner; owner is skipped while bursting.
    rr_pick4 u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .exclude (state_q == ST_BURST),
        .win_c   (pick_c)
    );

    // Capture decision and winner selection.
    always_comb begin
        cap_c  = (!valid_q || bus.out_ready) && (|bus.req);
        hold_c = (state_q == ST_BURST) && bus.req[ptr_q] && (cnt_q < BCNT_W'(BURST_LEN));
        win_c  = hold_c ? ptr_q : pick_c;
        ack_c  = '0;
        if (cap_c && !rst) begin
            ack_c[win_c] = 1'b1;
        end
    end

    // Next-state logic for ownership pointer and burst count.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_c) begin
                    state_d = ST_BURST;
                    ptr_d   = win_c;
                    cnt_d   = BCNT_W'(1);
                end
            end
            ST_BURST: begin
                if (cap_c) begin
                    if (hold_c) begin
                        cnt_d = BCNT_W'(cnt_q + BCNT_W'(1));
                    end else begin
                        ptr_d = win_c;
                        cnt_d = BCNT_W'(1);
                    end
                end else if (!bus.req[ptr_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbitration state; ptr resets to 3 so requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // 4:1 select datapath driven by the winning index.
    always_comb begin
        case (win_c)
            2'd0:    win_data_c = bus.in0;
            2'd1:    win_data_c = bus.in1;
            2'd2:    win_data_c = bus.in2;
            default: win_data_c = bus.in3;
        endcase
    end

    // One-beat output buffer; a capture during drain replaces the old beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (cap_c) begin
            valid_q <= 1'b1;
            data_q  <= win_data_c;
            sel_q   <= win_c;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ack       = ack_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

`ifdef RR_MUX4_ARB_STATS_EN
    logic [CNT_W-1:0] gcnt_q [NUM_REQ];

    // Saturating ack counters; a clear coinciding with an ack leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (clr_stats) begin
                    gcnt_q[i] <= ack_c[i] ? CNT_W'(1) : '0;
                end else if (ack_c[i] && (gcnt_q[i] != {CNT_W{1'b1}})) begin
                    gcnt_q[i] <= CNT_W'(gcnt_q[i] + CNT_W'(1));
                end
            end
        end
    end

    assign grant_cnt0 = gcnt_q[0];
    assign grant_cnt1 = gcnt_q[1];
    assign grant_cnt2 = gcnt_q[2];
    assign grant_cnt3 = gcnt_q[3];
`endif

endmodule
